// File: rtl/apu_pkg.sv
// Shared definitions for the APU serial link (transmitter and receiver).
// APU_FRAME_CHECKSUM_EN appends an XOR checksum byte to every frame.
package apu_pkg;

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } tx_state_e;

  localparam int unsigned FRAME_W = 32;

`ifdef APU_FRAME_CHECKSUM_EN
  localparam int unsigned NBYTES = 5;
`else
  localparam int unsigned NBYTES = 4;
`endif

  // Rounded clocks-per-bit divisor.
  function automatic int unsigned baud_div(input int unsigned clkrate,
                                           input int unsigned baudrate);
    return (clkrate + baudrate / 2) / baudrate;
  endfunction

`ifdef APU_FRAME_CHECKSUM_EN
  function automatic logic [7:0] frame_xor(input logic [FRAME_W-1:0] f);
    logic [7:0] acc;
    acc = '0;
    for (int unsigned k = 0; k < FRAME_W / 8; k++) begin
      acc = acc ^ f[8*k +: 8];
    end
    return acc;
  endfunction
`endif

endpackage

// File: rtl/baud_tick.sv
// Bit-time divider: tick is high on the last cycle of every DIV-cycle window;
// restart realigns the window so the next cycle is its first.
module baud_tick #(
  parameter int unsigned DIV = 186
) (
  input  logic clk,
  input  logic reset,
  input  logic restart,
  output logic tick
);

  localparam int unsigned CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q + CW'(1);
    if (restart || (cnt_q == LAST)) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tick = (cnt_q == LAST);

endmodule

// File: rtl/apu_frame_tx.sv
// Serialises one 32-bit APU control frame as back-to-back 8N1 bytes on tx.
// APU_FRAME_CHECKSUM_EN adds a fifth byte holding the XOR of bytes 0..3.
module apu_frame_tx
  import apu_pkg::*;
#(
  parameter int unsigned CLKRATE  = 1_789_773,
  parameter int unsigned BAUDRATE = 9600
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               frame_valid,
  input  logic [FRAME_W-1:0] frame_data,
  output logic               frame_ready,
  output logic               tx,
  output logic               busy
);

  localparam int unsigned DIV = baud_div(CLKRATE, BAUDRATE);
  localparam int unsigned SHW = NBYTES * 8;
  localparam int unsigned BCW = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam logic [BCW-1:0] LAST_BYTE = BCW'(NBYTES - 1);

  tx_state_e      state_q, state_d;
  logic [SHW-1:0] shift_q, shift_d;
  logic [BCW-1:0] byte_q, byte_d;
  logic [2:0]     bit_q, bit_d;
  logic           tx_q, tx_d;
  logic           accept;
  logic           restart;
  logic           tick;
  logic [SHW-1:0] load_word;

`ifdef APU_FRAME_CHECKSUM_EN
  assign load_word = {frame_xor(frame_data), frame_data};
`else
  assign load_word = frame_data;
`endif

  assign frame_ready = (state_q == IDLE);
  assign busy        = ~frame_ready;
  assign tx          = tx_q;
  assign accept      = frame_valid && frame_ready;

  baud_tick #(
    .DIV(DIV)
  ) u_baud (
    .clk    (clk),
    .reset  (reset),
    .restart(restart),
    .tick   (tick)
  );

  // tx_d is decided on the transition edge so the line changes together with
  // the state; restart on every transition keeps each state exactly DIV long.
  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    byte_d  = byte_q;
    bit_d   = bit_q;
    tx_d    = tx_q;
    restart = 1'b0;
    case (state_q)
      IDLE: begin
        restart = 1'b1;
        tx_d    = 1'b1;
        if (accept) begin
          state_d = START;
          shift_d = load_word;
          byte_d  = '0;
          bit_d   = '0;
          tx_d    = 1'b0;
        end
      end
      START: begin
        if (tick) begin
          restart = 1'b1;
          state_d = DATA;
          bit_d   = '0;
          tx_d    = shift_q[0];
        end
      end
      DATA: begin
        if (tick) begin
          restart = 1'b1;
          shift_d = shift_q >> 1;
          if (bit_q == 3'd7) begin
            state_d = STOP;
            tx_d    = 1'b1;
          end else begin
            bit_d = bit_q + 3'd1;
            tx_d  = shift_q[1];
          end
        end
      end
      STOP: begin
        if (tick) begin
          restart = 1'b1;
          bit_d   = '0;
          if (byte_q == LAST_BYTE) begin
            state_d = IDLE;
            byte_d  = '0;
            tx_d    = 1'b1;
          end else begin
            state_d = START;
            byte_d  = byte_q + BCW'(1);
            tx_d    = 1'b0;
          end
        end
      end
      default: begin
        state_d = IDLE;
        tx_d    = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      shift_q <= '0;
      byte_q  <= '0;
      bit_q   <= '0;
      tx_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      byte_q  <= byte_d;
      bit_q   <= bit_d;
      tx_q    <= tx_d;
    end
  end

endmodule
